// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter (TX FIFO + 8N1 serialiser) on the Ibex data bus.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_periph #(
    parameter logic [15:0] DefaultBaudDiv = 16'd868,
    parameter int unsigned FifoDepth      = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        tx_idle_o
);
    localparam int unsigned AW        = $clog2(FifoDepth);
    localparam logic [AW:0] FullCount = (AW + 1)'(FifoDepth);
    localparam logic [15:0] ResetDiv  = (DefaultBaudDiv == 16'd0) ? 16'd1 : DefaultBaudDiv;
`ifdef UART_TX_PARITY_EN
    localparam logic ParityEn = 1'b1;
`else
    localparam logic ParityEn = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e        r_state, w_state_d;
    logic [7:0]    r_mem [FifoDepth];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic [15:0]   r_baud, w_baud_d, w_div_load;
    logic [15:0]   r_bit_cnt, r_cur_div;
    logic [2:0]    r_idx, w_idx_d;
    logic [7:0]    r_shift;
    logic          r_tx, w_tx_d;
    logic          r_rvalid;
    logic [31:0]   r_rdata, w_rd;
    logic          w_full, w_empty, w_push, w_push_ok, w_pop, w_ovf_set, w_ovf_clr;
    logic          w_bit_end, w_tx_idle, w_wr_status, w_wr_baud;
    logic [3:0]    w_cnt4;
    logic          w_unused;

    assign w_unused    = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};
    assign gnt_o       = req_i;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign tx_o        = r_tx;
    assign tx_idle_o   = w_tx_idle;

    assign w_full      = (r_count == FullCount);
    assign w_empty     = (r_count == '0);
    assign w_tx_idle   = (r_state == S_IDLE) && w_empty;
    assign w_cnt4      = 4'(r_count);
    assign w_push      = req_i && we_i && (addr_i[3:2] == 2'd0) && be_i[0];
    assign w_push_ok   = w_push && (!w_full || w_pop);
    assign w_ovf_set   = w_push && w_full && !w_pop;
    assign w_wr_status = req_i && we_i && (addr_i[3:2] == 2'd1);
    assign w_ovf_clr   = w_wr_status && be_i[0] && wdata_i[2];
    assign w_wr_baud   = req_i && we_i && (addr_i[3:2] == 2'd2);
    assign w_bit_end   = (r_bit_cnt == r_cur_div - 16'd1);

    // Divisor latched at each bit start sees a BAUD_DIV write landing on that same edge.
    always_comb begin
        w_baud_d = r_baud;
        if (w_wr_baud && be_i[0]) w_baud_d[7:0]  = wdata_i[7:0];
        if (w_wr_baud && be_i[1]) w_baud_d[15:8] = wdata_i[15:8];
        w_div_load = (w_baud_d == 16'd0) ? 16'd1 : w_baud_d;
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) r_mem[r_wptr] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_baud  <= DefaultBaudDiv;
        end else begin
            r_baud <= w_baud_d;
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_pop     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_state_d = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_d = S_DATA;
                    w_idx_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == 3'd7) w_state_d = ParityEn ? S_PARITY : S_STOP;
                    else               w_idx_d   = r_idx + 3'd1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) w_state_d = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_state_d = S_START;
                    end else begin
                        w_state_d = S_IDLE;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // tx_o is registered from the upcoming state so it changes with the state itself.
    always_comb begin
        w_tx_d = 1'b1;
        case (w_state_d)
            S_START:  w_tx_d = 1'b0;
            S_DATA:   w_tx_d = r_shift[w_idx_d];
            S_PARITY: w_tx_d = ^r_shift;
            default:  w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bit_cnt <= '0;
            r_cur_div <= ResetDiv;
            r_idx     <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_tx  <= w_tx_d;
            r_idx <= w_idx_d;
            if (w_pop) r_shift <= r_mem[r_rptr];
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_bit_cnt <= '0;
                r_cur_div <= w_div_load;
            end else begin
                r_bit_cnt <= r_bit_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (addr_i[3:2])
            2'd1:    w_rd[10:0] = {w_cnt4, 3'b000, ParityEn, r_ovf, w_tx_idle, w_full};
            2'd2:    w_rd[15:0] = r_baud;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= (req_i && !we_i) ? w_rd : '0;
        end
    end
endmodule
